core_n: RTL and testbench

//   Parametrised single-cycle accumulator core, next generation of the 2-bit core.
//   Two data registers (A, B), carry flag, registered output port and program counter.

---
 rtl/core_n.sv | 106 ++++++++++
 tb/tb_core_n.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_n.sv
// core_n: parametrised single-cycle accumulator core.
// Fetches one instruction per clock from an external combinational ROM addressed
// by the PC and updates A, B, carry, output register, PC and halt flag on one edge.
module core_n #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] in,
  input  logic [DATA_W+3:0] rom_value,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] out,
  output logic              halted
);

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_HLT    = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  logic [DATA_W-1:0] a, b;
  logic              c;
  logic [DATA_W-1:0] a_nxt, b_nxt, out_nxt;
  logic              c_nxt, halted_nxt;
  logic [ADDR_W-1:0] pc_nxt;

  logic [3:0]        op;
  logic [DATA_W-1:0] imm;
  logic [DATA_W:0]   sum_a, sum_b;
  logic [ADDR_W-1:0] pc_inc, jmp_target;
  logic              exec;

  // Instruction decode and datapath arithmetic shared by the next-state logic
  assign op         = rom_value[DATA_W+3:DATA_W];
  assign imm        = rom_value[DATA_W-1:0];
  assign sum_a      = {1'b0, a} + {1'b0, imm};
  assign sum_b      = {1'b0, b} + {1'b0, imm};
  assign pc_inc     = rom_addr + ADDR_W'(1);
  assign jmp_target = imm[ADDR_W-1:0];
  assign exec       = run && !halted;

  // State register: all architectural state, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a        <= '0;
      b        <= '0;
      c        <= 1'b0;
      rom_addr <= '0;
      out      <= '0;
      halted   <= 1'b0;
    end else begin
      a        <= a_nxt;
      b        <= b_nxt;
      c        <= c_nxt;
      rom_addr <= pc_nxt;
      out      <= out_nxt;
      halted   <= halted_nxt;
    end
  end

  // Next-state logic: hold everything unless executing, then apply the opcode
  always_comb begin
    a_nxt      = a;
    b_nxt      = b;
    c_nxt      = c;
    pc_nxt     = rom_addr;
    out_nxt    = out;
    halted_nxt = halted;
    if (exec) begin
      c_nxt  = 1'b0;
      pc_nxt = pc_inc;
      case (op)
        OP_ADD_A:  {c_nxt, a_nxt} = sum_a;
        OP_ADD_B:  {c_nxt, b_nxt} = sum_b;
        OP_MOV_AB: a_nxt = b;
        OP_MOV_BA: b_nxt = a;
        OP_IN_A:   a_nxt = in;
        OP_IN_B:   b_nxt = in;
        OP_MOV_AI: a_nxt = imm;
        OP_MOV_BI: b_nxt = imm;
        OP_OUT_B:  out_nxt = b;
        OP_OUT_I:  out_nxt = imm;
        // JNC looks at the carry left by the previous executed instruction
        OP_JNC:    if (!c) pc_nxt = jmp_target;
        OP_JMP:    pc_nxt = jmp_target;
        OP_HLT: begin
          halted_nxt = 1'b1;
          pc_nxt     = rom_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_n.sv
// tb_core_n: directed programs for core_n with a scoreboard of expected
// (rom_addr, out, halted) triples checked one step after each clock edge.
module tb_core_n;

  logic       clock;
  logic       reset;
  logic       run;
  logic [3:0] in;
  logic [7:0] rom_value;
  logic [3:0] rom_addr;
  logic [3:0] out;
  logic       halted;

  logic [7:0] rom [16];

  typedef struct {
    logic [3:0] addr;
    logic [3:0] outv;
    logic       halt;
  } exp_t;

  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [7:0] NOP = 8'b1010_0000;

  core_n #(.DATA_W(4), .ADDR_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .in        (in),
    .rom_value (rom_value),
    .rom_addr  (rom_addr),
    .out       (out),
    .halted    (halted)
  );

  assign rom_value = rom[rom_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] ins(input logic [3:0] op, input logic [3:0] imm);
    return {op, imm};
  endfunction

  task automatic expect_state(input logic [3:0] ea, input logic [3:0] eo, input logic eh);
    exp_t e;
    e.addr = ea;
    e.outv = eo;
    e.halt = eh;
    sb.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    n_tests++;
    assert (rom_addr === e.addr) else begin
      n_fail++;
      $error("FAIL %s: rom_addr got %0d expected %0d", tag, rom_addr, e.addr);
    end
    n_tests++;
    assert (out === e.outv) else begin
      n_fail++;
      $error("FAIL %s: out got %0d expected %0d", tag, out, e.outv);
    end
    n_tests++;
    assert (halted === e.halt) else begin
      n_fail++;
      $error("FAIL %s: halted got %0d expected %0d", tag, halted, e.halt);
    end
  endtask

  // One clock edge, then check against the pushed expectation
  task automatic step(input logic [3:0] ea, input logic [3:0] eo, input logic eh,
                      input string tag);
    expect_state(ea, eo, eh);
    @(posedge clock);
    #1;
    compare(tag);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = NOP;
  endtask

  // Hold reset across an edge, check cleared outputs, release just after the edge
  task automatic do_reset(input string tag);
    reset = 1'b0;
    run   = 1'b0;
    in    = 4'd0;
    #1;
    expect_state(4'd0, 4'd0, 1'b0);
    compare(tag);
    @(posedge clock);
    #1;
    expect_state(4'd0, 4'd0, 1'b0);
    compare({tag, "_held"});
    reset = 1'b1;
    run   = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    in    = 4'd0;
    clear_rom();
    #2;

    // Program 1: ADD carry-out suppresses JNC, then OUT imm, MOV B,A, OUT B, HLT
    clear_rom();
    rom[0] = ins(4'b0011, 4'd14);
    rom[1] = ins(4'b0000, 4'd3);
    rom[2] = ins(4'b1110, 4'd0);
    rom[3] = ins(4'b1011, 4'd5);
    rom[4] = ins(4'b0100, 4'd0);
    rom[5] = ins(4'b1001, 4'd0);
    rom[6] = ins(4'b1000, 4'd0);
    do_reset("p1_reset");
    step(4'd1, 4'd0, 1'b0, "p1_mov");
    step(4'd2, 4'd0, 1'b0, "p1_add");
    step(4'd3, 4'd0, 1'b0, "p1_jnc_not_taken");
    step(4'd4, 4'd5, 1'b0, "p1_out_imm");
    step(4'd5, 4'd5, 1'b0, "p1_mov_ba");
    step(4'd6, 4'd1, 1'b0, "p1_out_b_a_wrapped");
    step(4'd6, 4'd1, 1'b1, "p1_hlt");
    step(4'd6, 4'd1, 1'b1, "p1_hlt_hold");

    // Program 2: IN/ADD B, JNC taken with C=0, IN 15 + 1 wraps to 0 with carry
    clear_rom();
    rom[0] = ins(4'b0110, 4'd0);
    rom[1] = ins(4'b0101, 4'd1);
    rom[2] = ins(4'b1110, 4'd4);
    rom[3] = ins(4'b1000, 4'd0);
    rom[4] = ins(4'b1001, 4'd0);
    rom[5] = ins(4'b0110, 4'd0);
    rom[6] = ins(4'b0101, 4'd1);
    rom[7] = ins(4'b1110, 4'd3);
    rom[8] = ins(4'b1001, 4'd0);
    rom[9] = ins(4'b1000, 4'd0);
    do_reset("p2_reset");
    in = 4'd9;
    step(4'd1, 4'd0, 1'b0, "p2_in_b");
    in = 4'd2;
    step(4'd2, 4'd0, 1'b0, "p2_add_b");
    step(4'd4, 4'd0, 1'b0, "p2_jnc_taken");
    step(4'd5, 4'd10, 1'b0, "p2_out_b_10");
    in = 4'd15;
    step(4'd6, 4'd10, 1'b0, "p2_in_b_15");
    in = 4'd3;
    step(4'd7, 4'd10, 1'b0, "p2_add_wrap");
    step(4'd8, 4'd10, 1'b0, "p2_jnc_carry_set");
    step(4'd9, 4'd0, 1'b0, "p2_out_b_0");
    step(4'd9, 4'd0, 1'b1, "p2_hlt");

    // Program 3: HLT holds rom_addr for ten cycles; run toggling has no effect
    clear_rom();
    rom[0] = ins(4'b0011, 4'd2);
    rom[1] = ins(4'b1000, 4'd0);
    do_reset("p3_reset");
    step(4'd1, 4'd0, 1'b0, "p3_mov");
    for (int i = 0; i < 9; i++) step(4'd1, 4'd0, 1'b1, "p3_halted");
    run = 1'b0;
    step(4'd1, 4'd0, 1'b1, "p3_halted_run0");
    run = 1'b1;
    step(4'd1, 4'd0, 1'b1, "p3_halted_run1");
    // Asynchronous reset between edges clears halted, then restarts at 0
    #3;
    reset = 1'b0;
    #1;
    expect_state(4'd0, 4'd0, 1'b0);
    compare("p3_async_reset");
    reset = 1'b1;
    step(4'd1, 4'd0, 1'b0, "p3_restart");
    step(4'd1, 4'd0, 1'b1, "p3_rehalt");

    // Program 4: three stalled cycles between ADD (C=1) and JNC leave state intact
    clear_rom();
    rom[0] = ins(4'b1011, 4'd9);
    rom[1] = ins(4'b0011, 4'd5);
    rom[2] = ins(4'b0000, 4'd12);
    rom[3] = ins(4'b1110, 4'd0);
    rom[4] = ins(4'b0100, 4'd0);
    rom[5] = ins(4'b1001, 4'd0);
    rom[6] = ins(4'b1000, 4'd0);
    do_reset("p4_reset");
    step(4'd1, 4'd9, 1'b0, "p4_out_imm");
    step(4'd2, 4'd9, 1'b0, "p4_mov");
    step(4'd3, 4'd9, 1'b0, "p4_add_carry");
    run = 1'b0;
    in  = 4'd7;
    for (int i = 0; i < 3; i++) step(4'd3, 4'd9, 1'b0, "p4_stall");
    run = 1'b1;
    step(4'd4, 4'd9, 1'b0, "p4_jnc_after_stall");
    step(4'd5, 4'd9, 1'b0, "p4_mov_ba");
    step(4'd6, 4'd1, 1'b0, "p4_out_b");
    step(4'd6, 4'd1, 1'b1, "p4_hlt");

    // Program 5: NOPs walk the PC through 0..15 and wrap; JMP 15 then NOP wraps
    clear_rom();
    do_reset("p5_reset");
    for (int i = 1; i <= 16; i++) step(4'(i), 4'd0, 1'b0, "p5_nop_walk");
    rom[0] = ins(4'b1111, 4'd15);
    step(4'd15, 4'd0, 1'b0, "p5_jmp15");
    step(4'd0, 4'd0, 1'b0, "p5_nop_wrap");

    // Program 1 again: asynchronous reset mid-run with out nonzero
    clear_rom();
    rom[0] = ins(4'b0011, 4'd14);
    rom[1] = ins(4'b0000, 4'd3);
    rom[2] = ins(4'b1110, 4'd0);
    rom[3] = ins(4'b1011, 4'd5);
    do_reset("p6_reset");
    step(4'd1, 4'd0, 1'b0, "p6_mov");
    step(4'd2, 4'd0, 1'b0, "p6_add");
    step(4'd3, 4'd0, 1'b0, "p6_jnc");
    step(4'd4, 4'd5, 1'b0, "p6_out_imm");
    #3;
    reset = 1'b0;
    #1;
    expect_state(4'd0, 4'd0, 1'b0);
    compare("p6_async_reset");
    reset = 1'b1;
    step(4'd1, 4'd0, 1'b0, "p6_restart_mov");
    step(4'd2, 4'd0, 1'b0, "p6_restart_add");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
